// File: rtl/microwave_timer_ctrl.sv
// ------------------------------------------------------------------------------------
// microwave_timer_ctrl: keypad preset entry plus cook/pause/done sequencing. Rev 1.0
// ------------------------------------------------------------------------------------
`default_nettype none

module microwave_timer_ctrl #(
   parameter int TICK_DIV   = 100,
   parameter int BEEP_TICKS = 3
) (
   input  logic        clock,
   input  logic        clr,
   input  logic        keypad_valid,
   input  logic [3:0]  keypad_digit,
   input  logic        start,
   input  logic        stop_clear,
   input  logic        door_closed,
   input  logic        timer_zero,
   output logic [15:0] load_data,
   output logic        counter_loadn,
   output logic        counter_clrn,
   output logic        count_enable,
   output logic        magnetron_on,
   output logic        beep,
   output logic [2:0]  state
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_LOAD  = 3'd2,
      S_COOK  = 3'd3,
      S_PAUSE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state_q;
   logic [15:0]     load_q;
   logic [PW-1:0]   presc_q;
   logic [BW-1:0]   beep_cnt_q;
   logic            loadn_q;
   logic            clrn_q;

   logic            presc_wrap;
   logic            start_ok;

   assign presc_wrap = (presc_q == PRESC_MAX);
   assign start_ok   = door_closed && (load_q != 16'h0000) && (load_q[7:4] <= 4'd5);

   always_ff @(posedge clock) begin
      if (clr) begin
         state_q    <= S_IDLE;
         load_q     <= '0;
         presc_q    <= '0;
         beep_cnt_q <= '0;
         loadn_q    <= 1'b1;
         clrn_q     <= 1'b0;
      end else begin
         loadn_q <= 1'b1;
         clrn_q  <= 1'b1;
         case (state_q)
            S_IDLE, S_ENTRY: begin
               if ((state_q == S_ENTRY) && stop_clear) begin
                  state_q <= S_IDLE;
                  load_q  <= '0;
                  presc_q <= '0;
                  clrn_q  <= 1'b0;
               end else if ((state_q == S_ENTRY) && start) begin
                  // A rejected start swallows any keypad strobe in the same cycle.
                  if (start_ok) begin
                     state_q <= S_LOAD;
                     loadn_q <= 1'b0;
                  end
               end else if (keypad_valid && (keypad_digit <= 4'd9)) begin
                  load_q  <= {load_q[11:0], keypad_digit};
                  state_q <= S_ENTRY;
               end
            end
            S_LOAD: begin
               presc_q <= '0;
               state_q <= S_COOK;
            end
            S_COOK: begin
               if (stop_clear) begin
                  state_q <= S_PAUSE;
               end else if (timer_zero) begin
                  state_q    <= S_DONE;
                  presc_q    <= '0;
                  beep_cnt_q <= '0;
               end else if (!door_closed) begin
                  state_q <= S_PAUSE;
               end else begin
                  presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
               end
            end
            S_PAUSE: begin
               if (stop_clear) begin
                  state_q <= S_IDLE;
                  load_q  <= '0;
                  presc_q <= '0;
                  clrn_q  <= 1'b0;
               end else if (start && door_closed) begin
                  state_q <= S_COOK;
               end
            end
            S_DONE: begin
               if (stop_clear || (presc_wrap && (beep_cnt_q == BEEP_MAX))) begin
                  state_q <= S_IDLE;
                  load_q  <= '0;
                  presc_q <= '0;
                  clrn_q  <= 1'b0;
               end else if (presc_wrap) begin
                  presc_q    <= '0;
                  beep_cnt_q <= beep_cnt_q + BW'(1);
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state         = state_q;
   assign load_data     = load_q;
   assign counter_loadn = loadn_q;
   assign counter_clrn  = clrn_q;
   // Gated by clr so an in-flight tick or heating request dies with the reset request.
   assign magnetron_on  = !clr && (state_q == S_COOK) && door_closed;
   assign beep          = !clr && (state_q == S_DONE);
   assign count_enable  = !clr && (state_q == S_COOK) && presc_wrap && door_closed
                          && !stop_clear && !timer_zero;

endmodule

`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
// ------------------------------------------------------------------------------------
// tb_microwave_timer_ctrl: directed, table and random checks for microwave_timer_ctrl. Rev 1.0
// ------------------------------------------------------------------------------------
`default_nettype none

module tb_microwave_timer_ctrl;

   localparam int TD = 4;
   localparam int BT = 2;

   logic        clock = 1'b0;
   logic        clr = 1'b1;
   logic        keypad_valid = 1'b0;
   logic [3:0]  keypad_digit = 4'd0;
   logic        start = 1'b0;
   logic        stop_clear = 1'b0;
   logic        door_closed = 1'b1;
   logic        timer_zero;
   logic [15:0] load_data;
   logic        counter_loadn, counter_clrn, count_enable, magnetron_on, beep;
   logic [2:0]  state;

   microwave_timer_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
      .clock(clock), .clr(clr), .keypad_valid(keypad_valid), .keypad_digit(keypad_digit),
      .start(start), .stop_clear(stop_clear), .door_closed(door_closed), .timer_zero(timer_zero),
      .load_data(load_data), .counter_loadn(counter_loadn), .counter_clrn(counter_clrn),
      .count_enable(count_enable), .magnetron_on(magnetron_on), .beep(beep), .state(state)
   );

   always #5 clock = ~clock;

   // mm:ss BCD down-counter chain driven by the controller outputs
   logic [3:0] c_mt = 4'd0, c_mo = 4'd0, c_st = 4'd0, c_so = 4'd0;
   logic       use_chain = 1'b1;
   logic       tz_force = 1'b0;
   assign timer_zero = use_chain ? ({c_mt, c_mo, c_st, c_so} == 16'h0000) : tz_force;

   always @(posedge clock) begin
      if (counter_clrn === 1'b0) begin
         {c_mt, c_mo, c_st, c_so} <= 16'h0000;
      end else if (counter_loadn === 1'b0) begin
         {c_mt, c_mo, c_st, c_so} <= load_data;
      end else if (count_enable === 1'b1) begin
         if (c_so != 4'd0) c_so <= c_so - 4'd1;
         else begin
            c_so <= 4'd9;
            if (c_st != 4'd0) c_st <= c_st - 4'd1;
            else begin
               c_st <= 4'd5;
               if (c_mo != 4'd0) c_mo <= c_mo - 4'd1;
               else begin
                  c_mo <= 4'd9;
                  c_mt <= c_mt - 4'd1;
               end
            end
         end
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
   endtask

   // advance past the next rising edge; one-cycle strobes drop afterwards
   task automatic cyc();
      @(posedge clock);
      #1;
      keypad_valid = 1'b0;
      start        = 1'b0;
      stop_clear   = 1'b0;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic key(input logic [3:0] d);
      keypad_valid = 1'b1;
      keypad_digit = d;
      cyc();
   endtask

   task automatic enter4(input logic [15:0] v);
      key(v[15:12]); key(v[11:8]); key(v[7:4]); key(v[3:0]);
   endtask

   typedef struct {
      logic        valid;
      logic [3:0]  digit;
      logic        st;
      logic        sc;
      logic        door;
      logic [2:0]  e_state;
      logic [15:0] e_load;
      logic        e_clrn;
   } vec_t;

   vec_t tv[14];

   // reference model: spec-level bookkeeping (elapsed cook phase, elapsed done cycles)
   int          m_state, m_phase, m_done;
   logic [15:0] m_load;
   logic        m_clrn, m_loadn;

   task automatic m_idle();
      m_state = 0; m_load = 16'h0; m_clrn = 1'b0; m_phase = 0;
   endtask

   task automatic model_step();
      if (clr) begin
         m_state = 0; m_load = 16'h0; m_phase = 0; m_done = 0; m_clrn = 1'b0; m_loadn = 1'b1;
         return;
      end
      m_clrn = 1'b1;
      m_loadn = 1'b1;
      case (m_state)
         0, 1: begin
            if (m_state == 1 && stop_clear) m_idle();
            else if (m_state == 1 && start) begin
               if (door_closed && m_load != 16'h0 && m_load[7:4] <= 4'd5) begin
                  m_state = 2; m_loadn = 1'b0;
               end
            end else if (keypad_valid && keypad_digit <= 4'd9) begin
               m_load = {m_load[11:0], keypad_digit};
               m_state = 1;
            end
         end
         2: begin m_phase = 0; m_state = 3; end
         3: begin
            if (stop_clear) m_state = 4;
            else if (timer_zero) begin m_state = 5; m_done = 0; end
            else if (!door_closed) m_state = 4;
            else m_phase = (m_phase + 1) % TD;
         end
         4: begin
            if (stop_clear) m_idle();
            else if (start && door_closed) m_state = 3;
         end
         5: begin
            if (stop_clear) m_idle();
            else begin
               m_done++;
               if (m_done == TD * BT) m_idle();
            end
         end
         default: m_idle();
      endcase
   endtask

   initial begin
      int nb;
      logic [23:0] act_v, exp_v;
      logic exp_ce, exp_mag, exp_beep;

      tv[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1};
      tv[1]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1};
      tv[2]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0007, 1'b1};
      tv[3]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0070, 1'b1};
      tv[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd1, 16'h0070, 1'b1};
      tv[5]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0070, 1'b1};
      tv[6]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0};
      tv[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1};
      tv[8]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1};
      tv[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd1, 16'h0000, 1'b1};
      tv[10] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0005, 1'b1};
      tv[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd1, 16'h0005, 1'b1};
      tv[12] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 3'd1, 16'h0059, 1'b1};
      tv[13] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0};

      // power-on reset
      clr = 1'b1;
      repeat (3) cyc();
      settle();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_load", 32'(load_data), 32'h0);
      chk("rst_loadn", 32'(counter_loadn), 32'd1);
      chk("rst_clrn", 32'(counter_clrn), 32'd0);
      chk("rst_ce", 32'(count_enable), 32'd0);
      chk("rst_mag", 32'(magnetron_on), 32'd0);
      chk("rst_beep", 32'(beep), 32'd0);
      clr = 1'b0;
      cyc();
      chk("rst_clrn_rel", 32'(counter_clrn), 32'd1);

      // entry validation table
      for (int i = 0; i < 14; i++) begin
         keypad_valid = tv[i].valid;
         keypad_digit = tv[i].digit;
         start        = tv[i].st;
         stop_clear   = tv[i].sc;
         door_closed  = tv[i].door;
         cyc();
         chk($sformatf("tv%0d_state", i), 32'(state), 32'(tv[i].e_state));
         chk($sformatf("tv%0d_load", i), 32'(load_data), 32'(tv[i].e_load));
         chk($sformatf("tv%0d_clrn", i), 32'(counter_clrn), 32'(tv[i].e_clrn));
         chk($sformatf("tv%0d_loadn", i), 32'(counter_loadn), 32'd1);
      end
      door_closed = 1'b1;
      cyc();

      // full cook of 3 s
      use_chain = 1'b1;
      enter4(16'h0003);
      chk("fc_load", 32'(load_data), 32'h0003);
      start = 1'b1;
      cyc();
      chk("fc_state_load", 32'(state), 32'd2);
      chk("fc_loadn_low", 32'(counter_loadn), 32'd0);
      cyc();
      chk("fc_state_cook", 32'(state), 32'd3);
      chk("fc_loadn_high", 32'(counter_loadn), 32'd1);
      for (int k = 0; k <= 12; k++) begin
         settle();
         chk($sformatf("fc_ce_c%0d", k), 32'(count_enable), 32'((k == 3) || (k == 7) || (k == 11)));
         chk($sformatf("fc_mag_c%0d", k), 32'(magnetron_on), 32'd1);
         cyc();
      end
      chk("fc_state_done", 32'(state), 32'd5);
      nb = 0;
      for (int i = 0; i < 20 && state == 3'd5; i++) begin
         settle();
         if (beep) nb++;
         cyc();
      end
      chk("fc_beep_len", 32'(nb), 32'(TD * BT));
      chk("fc_state_idle", 32'(state), 32'd0);
      chk("fc_clrn_pulse", 32'(counter_clrn), 32'd0);
      chk("fc_load_clr", 32'(load_data), 32'h0);
      cyc();
      chk("fc_clrn_back", 32'(counter_clrn), 32'd1);

      // door interlock during a 9 s cook
      enter4(16'h0009);
      start = 1'b1;
      cyc();
      cyc();
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("di_ce_c%0d", k), 32'(count_enable), 32'(k == 3));
         cyc();
      end
      door_closed = 1'b0;
      settle();
      chk("di_mag_open", 32'(magnetron_on), 32'd0);
      chk("di_ce_open", 32'(count_enable), 32'd0);
      chk("di_state_cook", 32'(state), 32'd3);
      cyc();
      chk("di_state_pause", 32'(state), 32'd4);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("di_ce_paused", 32'(count_enable), 32'd0);
         cyc();
      end
      door_closed = 1'b1;
      start = 1'b1;
      cyc();
      chk("di_resume", 32'(state), 32'd3);
      for (int r = 0; r < 3; r++) begin
         settle();
         chk($sformatf("di_ce_r%0d", r), 32'(count_enable), 32'(r == 2));
         chk("di_loadn", 32'(counter_loadn), 32'd1);
         cyc();
      end
      stop_clear = 1'b1;
      cyc();
      chk("sc_pause", 32'(state), 32'd4);
      stop_clear = 1'b1;
      cyc();
      chk("sc_idle", 32'(state), 32'd0);
      chk("sc_load", 32'(load_data), 32'h0);
      chk("sc_clrn", 32'(counter_clrn), 32'd0);
      cyc();
      chk("sc_clrn_back", 32'(counter_clrn), 32'd1);

      // start and stop_clear together in PAUSE
      enter4(16'h0009);
      start = 1'b1;
      cyc();
      cyc();
      stop_clear = 1'b1;
      cyc();
      chk("ss_pause", 32'(state), 32'd4);
      start = 1'b1;
      stop_clear = 1'b1;
      cyc();
      chk("ss_idle", 32'(state), 32'd0);
      chk("ss_clrn", 32'(counter_clrn), 32'd0);
      cyc();

      // timer_zero wins over door open
      use_chain = 1'b0;
      tz_force = 1'b0;
      enter4(16'h0010);
      start = 1'b1;
      cyc();
      cyc();
      cyc();
      tz_force = 1'b1;
      door_closed = 1'b0;
      settle();
      chk("zd_mag", 32'(magnetron_on), 32'd0);
      chk("zd_ce", 32'(count_enable), 32'd0);
      cyc();
      chk("zd_done", 32'(state), 32'd5);
      tz_force = 1'b0;
      door_closed = 1'b1;
      settle();
      chk("zd_beep", 32'(beep), 32'd1);
      stop_clear = 1'b1;
      cyc();
      chk("zd_idle", 32'(state), 32'd0);
      chk("zd_clrn", 32'(counter_clrn), 32'd0);
      cyc();

      // clr held 3 cycles mid-cook
      use_chain = 1'b1;
      enter4(16'h0100);
      start = 1'b1;
      cyc();
      repeat (6) cyc();
      clr = 1'b1;
      settle();
      chk("mr_mag_now", 32'(magnetron_on), 32'd0);
      chk("mr_ce_now", 32'(count_enable), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (i == 2) clr = 1'b0;
         settle();
         chk("mr_state", 32'(state), 32'd0);
         chk("mr_load", 32'(load_data), 32'h0);
         chk("mr_clrn", 32'(counter_clrn), 32'd0);
         chk("mr_mag", 32'(magnetron_on), 32'd0);
      end
      cyc();
      chk("mr_clrn_back", 32'(counter_clrn), 32'd1);
      chk("mr_state_after", 32'(state), 32'd0);

      // randomized run against the reference model
      use_chain = 1'b0;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      m_state = 0; m_load = 16'h0; m_phase = 0; m_done = 0; m_clrn = 1'b0; m_loadn = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         clr          = ($urandom_range(0, 99) == 0);
         stop_clear   = ($urandom_range(0, 15) == 0);
         start        = ($urandom_range(0, 3) == 0);
         keypad_valid = ($urandom_range(0, 1) == 0);
         keypad_digit = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 11) == 0) door_closed = ~door_closed;
         tz_force     = ($urandom_range(0, 9) == 0);
         settle();
         exp_mag  = !clr && m_state == 3 && door_closed;
         exp_beep = !clr && m_state == 5;
         exp_ce   = !clr && m_state == 3 && door_closed && !stop_clear && !timer_zero
                    && m_phase == TD - 1;
         act_v = {state, load_data, counter_loadn, counter_clrn, count_enable, magnetron_on, beep};
         exp_v = {3'(m_state), m_load, m_loadn, m_clrn, exp_ce, exp_mag, exp_beep};
         chk($sformatf("rnd%0d", n), 32'(act_v), 32'(exp_v));
         model_step();
         cyc();
      end
      clr = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
